// File: rtl/uart_fifo_tx.sv
// 8N1 UART transmitter that pulls one byte per frame from an upstream FIFO.
// The line is driven from a register; the FIFO read request is combinational in IDLE.
module uart_fifo_tx #(
    parameter int unsigned CLOCK_FREQ = 125_000_000,
    parameter int unsigned BAUD_RATE  = 115_200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable_i,
    input  logic        fifo_empty_i,
    output logic        fifo_rd_en_o,
    input  logic [7:0]  fifo_dout_i,
    output logic        serial_out_o,
    output logic        busy_o,
    output logic [15:0] frames_sent_o
);

    localparam int unsigned SYMBOL_CYCLES = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned CNT_W         = $clog2(SYMBOL_CYCLES);
    localparam int unsigned BIT_W         = 4;
    localparam int unsigned FRAME_BITS    = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2,
        SEND  = 2'd3
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [BIT_W-1:0]   bit_idx_q;
    logic [9:0]         shift_q;
    logic               serial_q;
    logic               busy_q;
    logic [15:0]        frames_sent_q;
    logic [15:0]        frames_sent_d;
    logic               sym_end_c;
    logic               frame_done_c;

    assign fifo_rd_en_o  = (state_q == IDLE) && enable_i && !fifo_empty_i && !rst;
    assign sym_end_c     = (cnt_q == CNT_W'(SYMBOL_CYCLES - 1));
    assign frame_done_c  = (state_q == SEND) && sym_end_c
                           && (bit_idx_q == BIT_W'(FRAME_BITS - 1));
    assign frames_sent_d = frames_sent_q + 16'(frame_done_c);

    assign serial_out_o  = serial_q;
    assign busy_o        = busy_q;
    assign frames_sent_o = frames_sent_q;

    // serial_q is loaded with the value the line must show in the following cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            shift_q       <= 10'h3FF;
            serial_q      <= 1'b1;
            busy_q        <= 1'b0;
            frames_sent_q <= '0;
        end else begin
            frames_sent_q <= frames_sent_d;
            case (state_q)
                IDLE: begin
                    serial_q <= 1'b1;
                    if (fifo_rd_en_o) begin
                        state_q <= FETCH;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                FETCH: begin
                    shift_q   <= {1'b1, fifo_dout_i, 1'b0};
                    cnt_q     <= '0;
                    bit_idx_q <= '0;
                    serial_q  <= 1'b0;
                    busy_q    <= 1'b1;
                    state_q   <= SEND;
                end
                SEND: begin
                    if (sym_end_c) begin
                        cnt_q     <= '0;
                        shift_q   <= {1'b1, shift_q[9:1]};
                        bit_idx_q <= bit_idx_q + BIT_W'(1);
                        serial_q  <= shift_q[1];
                        if (frame_done_c) begin
                            state_q   <= IDLE;
                            busy_q    <= 1'b0;
                            serial_q  <= 1'b1;
                            bit_idx_q <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    busy_q   <= 1'b0;
                    serial_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Bench for uart_fifo_tx: FIFO model, timestamp-based line model, vector table and corner sequences.
module tb_uart_fifo_tx;

    localparam int unsigned CLOCK_FREQ = 1000;
    localparam int unsigned BAUD_RATE  = 100;
    localparam int          SC         = 10;
    localparam int          FRAME      = 10 * SC;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [7:0]  fifo_dout;
    logic        serial_out;
    logic        busy;
    logic [15:0] frames_sent;

    uart_fifo_tx #(
        .CLOCK_FREQ(CLOCK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable_i     (enable),
        .fifo_empty_i (fifo_empty),
        .fifo_rd_en_o (fifo_rd_en),
        .fifo_dout_i  (fifo_dout),
        .serial_out_o (serial_out),
        .busy_o       (busy),
        .frames_sent_o(frames_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic [9:0]  line;    // line[k] = level of transmitted bit k
        logic [15:0] frames;
    } vec_t;

    vec_t        vec [6];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rd_count = 0;
    logic [7:0]  q [$];
    int          rd_cyc = -1;
    logic [7:0]  mbyte;
    logic [15:0] mfr;
    bit          armed = 1'b0;
    logic [7:0]  pop_byte;
    bit          pop_pending = 1'b0;
    logic        s_serial, s_busy, s_rd;
    logic [15:0] s_frames;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic line_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return d[k-1];
    endfunction

    task automatic push(input logic [7:0] b);
        q.push_back(b);
        fifo_empty = 1'b0;
    endtask

    // One clock: sample and check at the falling edge, then update the FIFO after the rising edge
    task automatic step();
        logic e_rd, e_busy, e_serial;
        int   off;
        @(negedge clk);
        cyc++;
        s_serial = serial_out;
        s_busy   = busy;
        s_rd     = fifo_rd_en;
        s_frames = frames_sent;
        if (s_rd) rd_count++;
        e_rd     = !rst && (rd_cyc < 0) && enable && !fifo_empty;
        e_busy   = 1'b0;
        e_serial = 1'b1;
        if (rd_cyc >= 0) begin
            off    = cyc - rd_cyc - 2;
            e_busy = 1'b1;
            if (off >= 0) e_serial = line_bit(mbyte, off / SC);
        end
        if (armed) begin
            chk("rd_en", 32'(s_rd), 32'(e_rd));
            chk("busy", 32'(s_busy), 32'(e_busy));
            chk("serial_out", 32'(s_serial), 32'(e_serial));
            chk("frames_sent", 32'(s_frames), 32'(mfr));
        end
        if (rst) begin
            rd_cyc = -1;
            mfr    = '0;
            armed  = 1'b1;
        end else begin
            if (rd_cyc >= 0 && cyc == rd_cyc + 1 + FRAME) begin
                rd_cyc = -1;
                mfr++;
            end
            if (e_rd) begin
                rd_cyc = cyc;
                mbyte  = q[0];
            end
        end
        if (fifo_rd_en && !fifo_empty) begin
            pop_byte    = q.pop_front();
            pop_pending = 1'b1;
        end
        @(posedge clk);
        #1;
        fifo_dout   = pop_pending ? pop_byte : 8'($urandom);
        pop_pending = 1'b0;
        fifo_empty  = (q.size() == 0);
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic wait_rd(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit && at < 0; i++) begin
            step();
            if (s_rd) at = cyc;
        end
        chk("rd_seen", 32'(at >= 0), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int at, a0, a1, a2, r0;
        vec[0] = '{8'hA5, 10'h34A, 16'd1};
        vec[1] = '{8'h00, 10'h200, 16'd2};
        vec[2] = '{8'hFF, 10'h3FE, 16'd3};
        vec[3] = '{8'h3C, 10'h278, 16'd4};
        vec[4] = '{8'h55, 10'h2AA, 16'd5};
        vec[5] = '{8'h81, 10'h302, 16'd6};

        rst        = 1'b1;
        enable     = 1'b0;
        fifo_empty = 1'b1;
        fifo_dout  = '0;
        mfr        = '0;
        repeat (3) step();
        chk("reset_serial", 32'(s_serial), 32'd1);
        chk("reset_busy", 32'(s_busy), 32'd0);
        chk("reset_frames", 32'(s_frames), 32'd0);
        chk("reset_rd_en", 32'(s_rd), 32'd0);

        // Empty FIFO with enable high: no reads, line idle
        rst    = 1'b0;
        enable = 1'b1;
        r0     = rd_count;
        repeat (500) step();
        chk("empty_rd_pulses", 32'(rd_count - r0), 32'd0);
        chk("empty_serial", 32'(s_serial), 32'd1);
        chk("empty_busy", 32'(s_busy), 32'd0);

        // Single-byte frames decoded mid-bit against the table
        for (int i = 0; i < 6; i++) begin
            push(vec[i].data);
            wait_rd(20, at);
            for (int k = 0; k < 10; k++) begin
                step_to(at + 2 + k * SC + SC / 2);
                chk("tbl_line_bit", 32'(s_serial), 32'(vec[i].line[k]));
            end
            step_to(at + 2 + FRAME);
            chk("tbl_frames", 32'(s_frames), 32'(vec[i].frames));
            chk("tbl_busy_after", 32'(s_busy), 32'd0);
        end

        // Back-to-back frames
        push(8'h00);
        push(8'hFF);
        push(8'h3C);
        wait_rd(20, a0);
        wait_rd(FRAME + 20, a1);
        wait_rd(FRAME + 20, a2);
        chk("b2b_gap1", 32'(a1 - a0), 32'(FRAME + 2));
        chk("b2b_gap2", 32'(a2 - a1), 32'(FRAME + 2));
        step_to(a2 + 2 + FRAME);
        chk("b2b_frames", 32'(s_frames), 32'd9);

        // Enable dropped mid-frame
        push(8'h55);
        push(8'h12);
        wait_rd(20, at);
        step_to(at + 30);
        enable = 1'b0;
        r0     = rd_count;
        step_to(at + 2 + FRAME + 50);
        chk("en_low_no_rd", 32'(rd_count - r0), 32'd0);
        chk("en_low_frames", 32'(s_frames), 32'd10);
        chk("en_low_busy", 32'(s_busy), 32'd0);
        enable = 1'b1;
        wait_rd(5, at);
        step_to(at + 2 + FRAME);
        chk("en_resume_frames", 32'(s_frames), 32'd11);

        // Reset in the middle of a frame with another byte waiting
        push(8'h81);
        wait_rd(20, at);
        step_to(at + 34);
        rst = 1'b1;
        push(8'hC3);
        r0 = rd_count;
        step();
        step();
        chk("rst_serial", 32'(s_serial), 32'd1);
        chk("rst_busy", 32'(s_busy), 32'd0);
        chk("rst_frames", 32'(s_frames), 32'd0);
        step();
        rst = 1'b0;
        chk("rst_no_rd", 32'(rd_count - r0), 32'd0);
        wait_rd(20, at);
        step_to(at + 2 + FRAME);
        chk("rst_next_frames", 32'(s_frames), 32'd1);

        // Frame counter wrap from a preloaded value
        force dut.frames_sent_q = 16'hFFFF;
        mfr = 16'hFFFF;
        step();
        release dut.frames_sent_q;
        step();
        chk("wrap_preload", 32'(s_frames), 32'h0000_FFFF);
        push(8'h3C);
        wait_rd(20, at);
        step_to(at + 1 + FRAME);
        chk("wrap_before", 32'(s_frames), 32'h0000_FFFF);
        step();
        chk("wrap_after", 32'(s_frames), 32'd0);

        // Random traffic against the line model
        for (int i = 0; i < 3000; i++) begin
            if (($urandom % 4) == 0 && q.size() < 4) push(8'($urandom));
            enable = ($urandom % 8) != 0;
            rst    = ($urandom % 500) == 0;
            step();
        end
        rst    = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 2000 && !(q.size() == 0 && !s_busy && !s_rd); i++) step();
        chk("drain_idle", 32'(q.size() == 0 && !s_busy), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
